// File: rtl/cmd_pkg.sv
// Shared definitions for the command frame parser: FSM state encodings,
// error codes and the default header bytes.
package cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_H0   = 4'd1,
        ST_H1   = 4'd2,
        ST_DEV  = 4'd3,
        ST_LEN  = 4'd4,
        ST_PAY  = 4'd5,
        ST_CSUM = 4'd6,
        ST_DONE = 4'd7,
        ST_ERR  = 4'd8
    } state_e;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_HDR  = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_CSUM = 3'd3;
    localparam logic [2:0] ERR_TOUT = 3'd4;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

    // States that are waiting on a FIFO byte.
    function automatic logic needs_byte(input state_e s);
        return (s == ST_H0) || (s == ST_H1) || (s == ST_DEV) || (s == ST_LEN) ||
               (s == ST_PAY) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/cmd_byte_fetch.sv
// FIFO read-side handshake: issues one read at a time and flags the returned
// byte as valid in the cycle after the read enable.
module cmd_byte_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       need,
    input  logic       fifoc_empty,
    input  logic [7:0] fifoc_rxd,
    output logic       fifoc_rxen,
    output logic       byte_vld,
    output logic [7:0] byte_data
);

    logic pend_q;
    logic pend_d;

    always_comb begin
        fifoc_rxen = need && !fifoc_empty && !pend_q;
        pend_d     = fifoc_rxen;
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

    assign byte_vld  = pend_q;
    assign byte_data = fifoc_rxd;

endmodule

// File: rtl/cmd_frame_parser.sv
// Framed command parser: fetches HEAD0 HEAD1 DEV LEN payload CSUM from the
// command FIFO and commits atomically. Optional idle timeout: CMD_TIMEOUT_EN.
module cmd_frame_parser #(
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] HEAD0       = cmd_pkg::HEAD0_DEF,
    parameter logic [7:0] HEAD1       = cmd_pkg::HEAD1_DEF,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fs,
    output logic                  fd,
    input  logic                  fifoc_empty,
    output logic                  fifoc_rxen,
    input  logic [7:0]            fifoc_rxd,
    output logic [7:0]            kind_dev,
    output logic [NUM_REGS*8-1:0] cmd_regs,
    output logic [7:0]            cmd_len,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [7:0]            check_show,
    output logic [7:0]            frame_cnt
);
    import cmd_pkg::*;

`ifdef CMD_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif
    localparam int RW = NUM_REGS * 8;

    state_e        state_q,  state_d;
    logic [7:0]    sh_kind_q, sh_kind_d, sh_len_q, sh_len_d;
    logic [RW-1:0] sh_regs_q, sh_regs_d;
    logic [7:0]    pay_idx_q, pay_idx_d, xor_q, xor_d;
    logic [7:0]    kind_q, kind_d, len_q, len_d, show_q, show_d, cnt_q, cnt_d;
    logic [RW-1:0] regs_q, regs_d;
    logic          err_q, err_d;
    logic [2:0]    code_q, code_d;
    logic [31:0]   tout_q, tout_d;

    logic          need, byte_vld, tout_hit, fail;
    logic [7:0]    byte_data;
    logic [2:0]    fail_code;

    assign need = needs_byte(state_q);

    cmd_byte_fetch u_fetch (
        .clk         (clk),
        .rst         (rst),
        .need        (need),
        .fifoc_empty (fifoc_empty),
        .fifoc_rxd   (fifoc_rxd),
        .fifoc_rxen  (fifoc_rxen),
        .byte_vld    (byte_vld),
        .byte_data   (byte_data)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        sh_kind_d = sh_kind_q;
        sh_len_d  = sh_len_q;
        sh_regs_d = sh_regs_q;
        pay_idx_d = pay_idx_q;
        xor_d     = xor_q;
        kind_d    = kind_q;
        len_d     = len_q;
        regs_d    = regs_q;
        show_d    = show_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        code_d    = code_q;
        tout_d    = tout_q;
        tout_hit  = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;

        if (need) begin
            if (byte_vld) begin
                tout_d = '0;
            end else begin
                tout_d   = tout_q + 32'd1;
                tout_hit = TOUT_EN && (tout_d == 32'(TIMEOUT_CYC));
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (fs) begin
                    state_d   = ST_H0;
                    err_d     = 1'b0;
                    code_d    = ERR_NONE;
                    xor_d     = '0;
                    tout_d    = '0;
                    pay_idx_d = '0;
                    // Shadow starts as the committed image so short frames keep upper regs.
                    sh_kind_d = kind_q;
                    sh_len_d  = len_q;
                    sh_regs_d = regs_q;
                end
            end
            ST_H0: if (byte_vld) begin
                if (byte_data == HEAD0) state_d = ST_H1;
                else begin fail = 1'b1; fail_code = ERR_HDR; end
            end
            ST_H1: if (byte_vld) begin
                if (byte_data == HEAD1) state_d = ST_DEV;
                else begin fail = 1'b1; fail_code = ERR_HDR; end
            end
            ST_DEV: if (byte_vld) begin
                sh_kind_d = byte_data;
                xor_d     = xor_q ^ byte_data;
                state_d   = ST_LEN;
            end
            ST_LEN: if (byte_vld) begin
                if (byte_data == 8'd0 || int'(byte_data) > NUM_REGS) begin
                    fail      = 1'b1;
                    fail_code = ERR_LEN;
                end else begin
                    sh_len_d  = byte_data;
                    xor_d     = xor_q ^ byte_data;
                    pay_idx_d = '0;
                    state_d   = ST_PAY;
                end
            end
            ST_PAY: if (byte_vld) begin
                sh_regs_d[int'(pay_idx_q)*8 +: 8] = byte_data;
                xor_d     = xor_q ^ byte_data;
                pay_idx_d = pay_idx_q + 8'd1;
                if (pay_idx_q + 8'd1 == sh_len_q) state_d = ST_CSUM;
            end
            ST_CSUM: if (byte_vld) begin
                show_d = byte_data;
                if (byte_data == xor_q) begin
                    state_d = ST_DONE;
                    kind_d  = sh_kind_q;
                    regs_d  = sh_regs_q;
                    len_d   = sh_len_q;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_CSUM;
                end
            end
            ST_DONE, ST_ERR: if (!fs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (tout_hit) begin
            fail      = 1'b1;
            fail_code = ERR_TOUT;
        end
        if (fail) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = fail_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            // NOTE: shadow and committed registers are reset as well: all outputs and the shadow buffer read 0 after rst.
            sh_kind_q <= '0;
            sh_len_q  <= '0;
            sh_regs_q <= '0;
            pay_idx_q <= '0;
            xor_q     <= '0;
            kind_q    <= '0;
            len_q     <= '0;
            regs_q    <= '0;
            show_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            tout_q    <= '0;
        end else begin
            state_q   <= state_d;
            sh_kind_q <= sh_kind_d;
            sh_len_q  <= sh_len_d;
            sh_regs_q <= sh_regs_d;
            pay_idx_q <= pay_idx_d;
            xor_q     <= xor_d;
            kind_q    <= kind_d;
            len_q     <= len_d;
            regs_q    <= regs_d;
            show_q    <= show_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
            tout_q    <= tout_d;
        end
    end

    assign fd         = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign kind_dev   = kind_q;
    assign cmd_regs   = regs_q;
    assign cmd_len    = len_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign check_show = show_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed self-checking bench for cmd_frame_parser with a small FIFO model.
module tb_cmd_frame_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs  = 1'b0;
    logic        fd;
    logic        fifoc_empty;
    logic        fifoc_rxen;
    logic [7:0]  fifoc_rxd = 8'h00;
    logic [7:0]  kind_dev;
    logic [63:0] cmd_regs;
    logic [7:0]  cmd_len;
    logic        err;
    logic [2:0]  err_code;
    logic [7:0]  check_show;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    // FIFO model: tasks push at wr_ptr, DUT reads advance rd_ptr.
    logic [7:0] mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   viol   = 0;
    logic starve = 1'b0;

    assign fifoc_empty = (rd_ptr == wr_ptr) || starve;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifoc_rxen && !fifoc_empty) begin
            fifoc_rxd <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifoc_rxen && fifoc_empty) viol <= viol + 1;
    end

    cmd_frame_parser #(
        .NUM_REGS    (8),
        .HEAD0       (8'h55),
        .HEAD1       (8'hAA),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fs          (fs),
        .fd          (fd),
        .fifoc_empty (fifoc_empty),
        .fifoc_rxen  (fifoc_rxen),
        .fifoc_rxd   (fifoc_rxd),
        .kind_dev    (kind_dev),
        .cmd_regs    (cmd_regs),
        .cmd_len     (cmd_len),
        .err         (err),
        .err_code    (err_code),
        .check_show  (check_show),
        .frame_cnt   (frame_cnt)
    );

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Raise fs and wait (bounded) for fd; optionally starve the FIFO every other cycle.
    task automatic frame_wait(input bit toggle);
        int n;
        fs = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL err_clear_on_start: err=%b code=%0d, want 0/0", err, err_code);
        end
        for (n = 0; n < 400; n++) begin
            if (fd === 1'b1) break;
            @(posedge clk); #1;
            if (toggle) starve = ~starve;
        end
        starve = 1'b0;
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL fd_wait: fd=%b after %0d cycles, want 1", fd, n);
        end
    endtask

    task automatic end_frame();
        fs = 1'b0;
        #1;
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL fd_before_drop: fd=%b, want 1", fd);
        end
        @(posedge clk); #1;
        checks++;
        if (fd !== 1'b0) begin
            errors++;
            $display("FAIL fd_after_drop: fd=%b, want 0", fd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fd, err, err_code, fifoc_rxen} !== 6'b0 || kind_dev !== 8'h00 || cmd_regs !== 64'h0 ||
            cmd_len !== 8'h00 || check_show !== 8'h00 || frame_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: fd=%b err=%b code=%0d kind=%h regs=%h len=%h show=%h cnt=%h, want all 0",
                     fd, err, err_code, kind_dev, cmd_regs, cmd_len, check_show, frame_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        // CSUM = 02^03^11^22^33 = 01
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h02); push_byte(8'h03);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h01);
        frame_wait(1'b0);
        checks++;
        if (err !== 1'b0 || err_code !== 3'd0 || kind_dev !== 8'h02 || cmd_regs !== 64'h0000_0000_0033_2211 ||
            cmd_len !== 8'd3 || frame_cnt !== 8'd1 || check_show !== 8'h01) begin
            errors++;
            $display("FAIL good_frame: err=%b code=%0d kind=%h regs=%h len=%0d cnt=%0d show=%h, want 0/0/02/..332211/3/1/01",
                     err, err_code, kind_dev, cmd_regs, cmd_len, frame_cnt, check_show);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (fd !== 1'b1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL done_hold: fd=%b cnt=%0d, want 1/1", fd, frame_cnt);
        end
        end_frame();
    endtask

    task automatic test_bad_header();
        int start;
        start = rd_ptr;
        push_byte(8'h55); push_byte(8'hAB); push_byte(8'h02); push_byte(8'h03);
        frame_wait(1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || (rd_ptr - start) != 2) begin
            errors++;
            $display("FAIL bad_header: err=%b code=%0d reads=%0d, want 1/1/2", err, err_code, rd_ptr - start);
        end
        checks++;
        if (kind_dev !== 8'h02 || cmd_regs !== 64'h0000_0000_0033_2211 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_header_hold: kind=%h regs=%h cnt=%0d, want 02/..332211/1", kind_dev, cmd_regs, frame_cnt);
        end
        end_frame();
        wr_ptr = rd_ptr;
    endtask

    task automatic test_bad_length();
        for (int t = 0; t < 2; t++) begin
            push_byte(8'h55); push_byte(8'hAA); push_byte(8'h01); push_byte(t == 0 ? 8'h09 : 8'h00);
            frame_wait(1'b0);
            checks++;
            if (err !== 1'b1 || err_code !== 3'd2 || kind_dev !== 8'h02 || cmd_len !== 8'd3) begin
                errors++;
                $display("FAIL bad_length_%0d: err=%b code=%0d kind=%h len=%0d, want 1/2/02/3",
                         t, err, err_code, kind_dev, cmd_len);
            end
            end_frame();
        end
    endtask

    task automatic test_bad_csum();
        // 07^02^AA^BB = 14; send 15
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h07); push_byte(8'h02);
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'h15);
        frame_wait(1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3 || check_show !== 8'h15 || kind_dev !== 8'h02 ||
            cmd_regs !== 64'h0000_0000_0033_2211 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_csum: err=%b code=%0d show=%h kind=%h regs=%h cnt=%0d, want 1/3/15/02/..332211/1",
                     err, err_code, check_show, kind_dev, cmd_regs, frame_cnt);
        end
        end_frame();
    endtask

    task automatic test_starve();
        // 09^02^5A^A5 = F4; reg2 keeps 33 from the first frame
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h09); push_byte(8'h02);
        push_byte(8'h5A); push_byte(8'hA5); push_byte(8'hF4);
        frame_wait(1'b1);
        checks++;
        if (err !== 1'b0 || kind_dev !== 8'h09 || cmd_regs !== 64'h0000_0000_0033_A55A ||
            cmd_len !== 8'd2 || frame_cnt !== 8'd2 || check_show !== 8'hF4) begin
            errors++;
            $display("FAIL starve_frame: err=%b kind=%h regs=%h len=%0d cnt=%0d show=%h, want 0/09/..33A55A/2/2/F4",
                     err, kind_dev, cmd_regs, cmd_len, frame_cnt, check_show);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL rxen_while_empty: count=%0d, want 0", viol);
        end
        end_frame();
    endtask

    task automatic test_timeout();
`ifdef CMD_TIMEOUT_EN
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h01);
        frame_wait(1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL timeout: err=%b code=%0d cnt=%0d, want 1/4/2", err, err_code, frame_cnt);
        end
        end_frame();
        wr_ptr = rd_ptr;
`endif
    endtask

    task automatic test_reset_mid_frame();
        int start;
        start = rd_ptr;
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h03); push_byte(8'h03); push_byte(8'h11);
        fs = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (fd !== 1'b0 || (rd_ptr - start) != 5) begin
            errors++;
            $display("FAIL mid_frame_progress: fd=%b reads=%0d, want 0/5", fd, rd_ptr - start);
        end
        rst = 1'b1;
        fs  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({fd, err, err_code, fifoc_rxen} !== 6'b0 || kind_dev !== 8'h00 || cmd_regs !== 64'h0 ||
            cmd_len !== 8'h00 || check_show !== 8'h00 || frame_cnt !== 8'h00) begin
            errors++;
            $display("FAIL mid_frame_reset: fd=%b err=%b kind=%h regs=%h len=%h show=%h cnt=%h, want all 0",
                     fd, err, kind_dev, cmd_regs, cmd_len, check_show, frame_cnt);
        end
        rst = 1'b0;
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        // 04^01^77 = 72
        push_byte(8'h55); push_byte(8'hAA); push_byte(8'h04); push_byte(8'h01);
        push_byte(8'h77); push_byte(8'h72);
        frame_wait(1'b0);
        checks++;
        if (err !== 1'b0 || kind_dev !== 8'h04 || cmd_regs !== 64'h77 || cmd_len !== 8'd1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL after_reset_frame: err=%b kind=%h regs=%h len=%0d cnt=%0d, want 0/04/77/1/1",
                     err, kind_dev, cmd_regs, cmd_len, frame_cnt);
        end
        end_frame();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 255; k++) begin
            push_byte(8'h55); push_byte(8'hAA); push_byte(8'h01); push_byte(8'h01);
            push_byte(8'(k)); push_byte(8'(k));
            frame_wait(1'b0);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_frame_%0d: err=%b code=%0d, want 0", k, err, err_code);
            end
            end_frame();
        end
        checks++;
        if (frame_cnt !== 8'd0 || kind_dev !== 8'h01 || cmd_regs !== 64'hFE || check_show !== 8'hFE) begin
            errors++;
            $display("FAIL frame_cnt_wrap: cnt=%0d kind=%h regs=%h show=%h, want 0/01/FE/FE",
                     frame_cnt, kind_dev, cmd_regs, check_show);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_header();
        test_bad_length();
        test_bad_csum();
        test_starve();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
